fdiv_seq: RTL
=============

Name: fdiv_seq

Overview:
- Iterative IEEE-754 single-precision divider, z = a / b; the inverse operator to the team's combinational multiplier.
- Same exception-flag set as the multiplier, plus a divide-by-zero flag.
- Restoring radix-2 mantissa division, one quotient bit per clock; valid/ready handshakes on input and output.
- Sits beside the multiplier in the FP datapath and uses the same 32-bit operand format.

Parameters:
- SPECIAL_FAST, 1: 1 = special-case operands (NaN/Inf/zero) complete in 1 cycle; 0 = fixed latency for every operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high; all state cleared immediately
- in_valid  in  1  operands a, b present
- in_ready  out  1  high only in IDLE
- a  in  32  dividend, IEEE-754 single
- b  in  32  divisor, IEEE-754 single
- out_valid  out  1  result and flags valid; held until out_ready
- out_ready  in  1  consumer accepts the result
- z  out  32  quotient
- NAN  out  1  result is NaN
- zero  out  1  result is ±0, from a zero operand or b infinite
- underflow  out  1  exponent underflow, flushed to ±0
- overflow  out  1  exponent overflow, result ±Inf
- div_by_zero  out  1  finite nonzero a divided by ±0

Behaviour:
- Reset values: in_ready=1 (state IDLE), out_valid=0, z=0, all flags 0, all internal registers 0. Reset in any state aborts the operation with no output.
- Input handshake: a transfer occurs on the edge T where in_valid & in_ready. Operands are captured at that edge; later input changes are ignored.
- States: IDLE → PREP → DIV → ROUND → DONE → IDLE.
- IDLE:
  - Classify operands. Exponent 0 is treated as zero; denormals are flushed.
  - NaN = exp 255 and fraction ≠ 0.
  - Sign = a[31]^b[31].
- Special cases (priority order):
  1. Either operand NaN, 0/0, or Inf/Inf → z=32'h7FC00000, NAN=1.
  2. a Inf, or b zero with a finite nonzero → z={sign,8'hFF,23'b0}. Set div_by_zero only for the b-zero case.
  3. a zero, or b Inf → z={sign,31'b0}, zero=1.
- Special-case timing: if SPECIAL_FAST=1, go directly to DONE, with out_valid high after edge T+1. If SPECIAL_FAST=0, traverse all states, with out_valid high after edge T+28.
- PREP (edge T+1):
  - ma={1,a[22:0]}, mb={1,b[22:0]}.
  - e = ea − eb + 127, held as a 10-bit signed value.
  - If ma < mb: ma <<= 1 and e −= 1, so that the quotient lies in [1,2).
- DIV (edges T+2..T+27), 26 iterations:
  - trial = rem − mb; if trial ≥ 0 then rem = trial and qbit=1, else qbit=0.
  - rem <<= 1. q = {q, qbit}. The first remainder is ma.
  - Result q[25:0]: q[25]=1 (hidden bit), q[24:2] = fraction, q[1] = guard, q[0] = round. Sticky = (final rem ≠ 0).
  - A 5-bit counter runs 0..25; the state exits when the counter reaches 25.
- ROUND (edge T+28):
  - Round to nearest even: increment when q[1] & (q[0] | sticky | q[2]).
  - Carry out of the fraction sets fraction=0 and e += 1.
  - If e ≥ 255: z=±Inf, overflow=1.
  - If e ≤ 0: z=±0, underflow=1, zero=1.
  - Otherwise z = {sign, e[7:0], fraction}.
- DONE:
  - out_valid=1; z and flags are stable.
  - Advance to IDLE on out_ready.
  - in_ready stays 0 until the cycle after the output handshake (no overlap).
- Flags are one-hot or all 0, except zero+underflow, which are set together. All flags clear when a new operation is accepted.
- out_ready is ignored outside DONE.

Decomposition:
- Shared package fp32_pkg:
  - Constants: BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000.
  - Field-extract functions: sign, exponent, fraction.
  - Classification function: returns an enum {ZERO, NORM, INF, NAN}.
  - State enum.
- One sub-module, fdiv_mant_step: combinational single restoring iteration (rem, mb) → (rem_next, qbit).
- Everything else lives in fdiv_seq.

Test Plan:
- 6.0/2.0: 40C00000 / 40000000 → z=40400000, no flags; out_valid exactly 28 cycles after accept.
- 1.0/3.0: 3F800000 / 40400000 → z=3EAAAAAB (rounding up exercised), no flags.
- Special cases, SPECIAL_FAST=1:
  - 3F800000 / 00000000 → z=7F800000, div_by_zero=1, at T+1.
  - 00000000 / 80000000 → z=7FC00000, NAN=1.
- Overflow: 7F000000 / 00800000 → z=7F800000, overflow=1.
- Underflow: 00800000 / 40000000 → z=00000000, underflow=1, zero=1.
- Back-pressure and reset:
  - Hold out_ready=0 for 10 cycles → z and flags stable, in_ready=0.
  - Assert rst at DIV iteration 12 → out_valid=0 and in_ready=1 immediately; the next operation (6.0/2.0) is still correct.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision helpers: field extraction, operand classes,
// and the sequential divider's state encoding.
package fp32_pkg;

    localparam int unsigned W      = 32;
    localparam int unsigned EW     = 8;
    localparam int unsigned FW     = 23;
    localparam int unsigned MW     = 24;   // mantissa incl. hidden bit
    localparam int unsigned QW     = 26;   // quotient bits produced
    localparam int unsigned RW     = 25;   // remainder width (rem < 2*mb)
    localparam int unsigned XW     = 10;   // signed working exponent
    localparam int unsigned CW     = 5;    // iteration counter
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam logic [W-1:0] QNAN   = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_cls_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_ROUND,
        S_DONE
    } state_e;

    function automatic logic fp_sign(input logic [W-1:0] x);
        return x[W-1];
    endfunction

    function automatic logic [EW-1:0] fp_exp(input logic [W-1:0] x);
        return x[W-2:FW];
    endfunction

    function automatic logic [FW-1:0] fp_frac(input logic [W-1:0] x);
        return x[FW-1:0];
    endfunction

    // Denormals (exponent 0) are flushed and classified as zero.
    function automatic fp_cls_e fp_class(input logic [W-1:0] x);
        if (fp_exp(x) == '0)
            return CLS_ZERO;
        if (fp_exp(x) == EW'(EXP_MAX))
            return (fp_frac(x) != '0) ? CLS_NAN : CLS_INF;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fdiv_mant_step.sv
// One restoring radix-2 division step: subtract the divisor if it fits,
// emit the quotient bit and shift the remainder left.
module fdiv_mant_step
    import fp32_pkg::*;
(
    input  logic [RW-1:0] i_rem,
    input  logic [MW-1:0] i_mb,
    output logic [RW-1:0] o_rem_next,
    output logic          o_qbit
);

    logic [RW:0]   w_trial;
    logic [RW-1:0] w_keep;

    assign w_trial    = {1'b0, i_rem} - (RW+1)'(i_mb);
    assign o_qbit     = ~w_trial[RW];
    assign w_keep     = o_qbit ? w_trial[RW-1:0] : i_rem;
    assign o_rem_next = w_keep << 1;

endmodule

// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 single-precision divider z = a / b, one quotient bit per
// clock, with valid/ready handshakes on both sides.
module fdiv_seq
    import fp32_pkg::*;
#(
    parameter bit SPECIAL_FAST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  z,
    output logic          NAN,
    output logic          zero,
    output logic          underflow,
    output logic          overflow,
    output logic          div_by_zero
);

    state_e        r_state;
    logic [W-1:0]  r_a, r_b;
    logic          r_sign;
    logic [XW-1:0] r_exp;
    logic [MW-1:0] r_mb;
    logic [RW-1:0] r_rem;
    logic [QW-2:0] r_q;        // hidden bit shifts out; q[24:0] remains
    logic [CW-1:0] r_cnt;
    logic          r_spec;
    logic [W-1:0]  r_spec_z;
    logic [4:0]    r_spec_flags;  // {nan, zero, underflow, overflow, div_by_zero}
    logic          r_in_ready, r_out_valid;
    logic [W-1:0]  r_z;
    logic [4:0]    r_flags;

    fp_cls_e       w_ca, w_cb;
    logic          w_sign;
    logic [MW-1:0] w_ma, w_mb;
    logic          w_ma_lt;
    logic          w_spec;
    logic [W-1:0]  w_spec_z;
    logic [4:0]    w_spec_flags;
    logic [RW-1:0] w_rem_next;
    logic          w_qbit;
    logic          w_sticky, w_inc;
    logic [MW-1:0] w_frac_sum;
    logic [XW-1:0] w_exp_r;
    logic [W-1:0]  w_rnd_z;
    logic [4:0]    w_rnd_flags;

    fdiv_mant_step u_step (
        .i_rem      (r_rem),
        .i_mb       (r_mb),
        .o_rem_next (w_rem_next),
        .o_qbit     (w_qbit)
    );

    assign w_ca    = fp_class(r_a);
    assign w_cb    = fp_class(r_b);
    assign w_sign  = fp_sign(r_a) ^ fp_sign(r_b);
    assign w_ma    = {1'b1, fp_frac(r_a)};
    assign w_mb    = {1'b1, fp_frac(r_b)};
    assign w_ma_lt = (w_ma < w_mb);

    // Special operands, highest priority first.
    always_comb begin
        w_spec       = 1'b1;
        w_spec_z     = '0;
        w_spec_flags = '0;
        if (w_ca == CLS_NAN || w_cb == CLS_NAN ||
            (w_ca == CLS_ZERO && w_cb == CLS_ZERO) ||
            (w_ca == CLS_INF && w_cb == CLS_INF)) begin
            w_spec_z     = QNAN;
            w_spec_flags = 5'b10000;
        end else if (w_ca == CLS_INF || w_cb == CLS_ZERO) begin
            w_spec_z     = {w_sign, 8'hFF, 23'b0};
            w_spec_flags = {4'b0000, (w_cb == CLS_ZERO && w_ca == CLS_NORM)};
        end else if (w_ca == CLS_ZERO || w_cb == CLS_INF) begin
            w_spec_z     = {w_sign, 31'b0};
            w_spec_flags = 5'b01000;
        end else begin
            w_spec       = 1'b0;
        end
    end

    // Round to nearest even, then range-check the biased exponent.
    assign w_sticky   = (r_rem != '0);
    assign w_inc      = r_q[1] & (r_q[0] | w_sticky | r_q[2]);
    assign w_frac_sum = {1'b0, r_q[QW-2:2]} + MW'(w_inc);
    assign w_exp_r    = r_exp + XW'(w_frac_sum[MW-1]);

    always_comb begin
        w_rnd_z     = {r_sign, w_exp_r[EW-1:0], w_frac_sum[FW-1:0]};
        w_rnd_flags = '0;
        if (r_spec) begin
            w_rnd_z     = r_spec_z;
            w_rnd_flags = r_spec_flags;
        end else if ($signed(w_exp_r) >= $signed(XW'(EXP_MAX))) begin
            w_rnd_z     = {r_sign, 8'hFF, 23'b0};
            w_rnd_flags = 5'b00010;
        end else if ($signed(w_exp_r) <= $signed(XW'(0))) begin
            w_rnd_z     = {r_sign, 31'b0};
            w_rnd_flags = 5'b01100;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_sign       <= 1'b0;
            r_exp        <= '0;
            r_mb         <= '0;
            r_rem        <= '0;
            r_q          <= '0;
            r_cnt        <= '0;
            r_spec       <= 1'b0;
            r_spec_z     <= '0;
            r_spec_flags <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_z          <= '0;
            r_flags      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_in_ready <= 1'b0;
                        r_z        <= '0;
                        r_flags    <= '0;
                        r_state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_sign       <= w_sign;
                    r_mb         <= w_mb;
                    r_rem        <= w_ma_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
                    r_exp        <= XW'(fp_exp(r_a)) - XW'(fp_exp(r_b)) + XW'(BIAS)
                                    - XW'(w_ma_lt);
                    r_q          <= '0;
                    r_cnt        <= '0;
                    r_spec       <= w_spec;
                    r_spec_z     <= w_spec_z;
                    r_spec_flags <= w_spec_flags;
                    if (SPECIAL_FAST && w_spec) begin
                        r_z         <= w_spec_z;
                        r_flags     <= w_spec_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state     <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[QW-3:0], w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(QW-1))
                        r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_z         <= w_rnd_z;
                    r_flags     <= w_rnd_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign z           = r_z;
    assign NAN         = r_flags[4];
    assign zero        = r_flags[3];
    assign underflow   = r_flags[2];
    assign overflow    = r_flags[1];
    assign div_by_zero = r_flags[0];

endmodule
